// File: rtl/hamming_top.sv
// Hamming(12,8) single-error-correcting loopback: encoder register, channel with optional
// compile-time bit flip, then syndrome decode/correct into the output register.
module hamming_top #(
    parameter int unsigned ERR_POS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic [7:0] q
);

    logic [11:0] encoder_out;
    logic [11:0] rx;
    logic [11:0] corrected;
    logic [3:0]  syndrome;
    logic [7:0]  extracted;

    // Position i lives at bit i-1; parity at positions 1, 2, 4 and 8.
    function automatic logic [11:0] encode(input logic [7:0] d);
        logic [11:0] cw;
        cw[2]  = d[0];
        cw[4]  = d[1];
        cw[5]  = d[2];
        cw[6]  = d[3];
        cw[8]  = d[4];
        cw[9]  = d[5];
        cw[10] = d[6];
        cw[11] = d[7];
        cw[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        cw[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        cw[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
        cw[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
        return cw;
    endfunction

    // Out-of-range ERR_POS yields an all-zero mask, disabling injection.
    function automatic logic [11:0] err_mask();
        logic [11:0] m;
        for (int unsigned i = 0; i < 12; i++) begin
            m[i] = (ERR_POS == i + 1);
        end
        return m;
    endfunction

    localparam logic [11:0] ErrMask = err_mask();

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            encoder_out <= 12'h000;
        end else begin
            encoder_out <= encode(data);
        end
    end

    assign rx = encoder_out ^ ErrMask;

    always_comb begin
        syndrome = 4'h0;
        for (int p = 1; p <= 12; p++) begin
            if (rx[p-1]) begin
                syndrome = syndrome ^ 4'(p);
            end
        end
    end

    // Syndromes 13..15 point outside the codeword: pass rx through uncorrected.
    always_comb begin
        corrected = rx;
        if (syndrome >= 4'd1 && syndrome <= 4'd12) begin
            corrected[syndrome - 4'd1] = ~rx[syndrome - 4'd1];
        end
    end

    assign extracted = {corrected[11], corrected[10], corrected[9], corrected[8],
                        corrected[6], corrected[5], corrected[4], corrected[2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 8'h00;
        end else begin
            q <= extracted;
        end
    end

endmodule

// File: tb/tb_hamming_top.sv
// Directed bench for hamming_top: one DUT per ERR_POS value 0..12, all sharing the same
// stimulus, checked against hand-computed codewords and the two-edge input-to-output delay.
module tb_hamming_top;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [7:0] q_all [13];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 13; g++) begin : g_dut
        hamming_top #(
            .ERR_POS(g)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .data(data),
            .q   (q_all[g])
        );
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] v;

        rst  = 1'b1;
        data = 8'h00;
        #12;
        check("rst_enc", 16'(g_dut[0].u_dut.encoder_out), 16'h000);
        check("rst_q", 16'(q_all[0]), 16'h00);
        tick();
        tick();
        rst = 1'b0;

        // Encoding, ERR_POS = 0
        data = 8'h00; tick();
        check("enc_00", 16'(g_dut[0].u_dut.encoder_out), 16'h000);
        data = 8'h01; tick();
        check("enc_01", 16'(g_dut[0].u_dut.encoder_out), 16'h007);
        check("q_lat_00", 16'(q_all[0]), 16'h00);
        data = 8'h80; tick();
        check("enc_80", 16'(g_dut[0].u_dut.encoder_out), 16'h888);
        check("enc_80_e12", 16'(g_dut[12].u_dut.encoder_out), 16'h888);
        check("q_01", 16'(q_all[0]), 16'h01);
        data = 8'hFF; tick();
        check("enc_ff", 16'(g_dut[0].u_dut.encoder_out), 16'hF77);
        check("q_80", 16'(q_all[0]), 16'h80);
        check("q_80_e12", 16'(q_all[12]), 16'h80);
        tick();
        check("q_ff", 16'(q_all[0]), 16'hFF);
        check("q_ff_e1", 16'(q_all[1]), 16'hFF);

        // Streaming latency
        data = 8'hA5; tick();
        data = 8'h3C; tick();
        check("stream_a5", 16'(q_all[0]), 16'hA5);
        tick();
        check("stream_3c", 16'(q_all[0]), 16'h3C);

        // Asynchronous reset mid-stream
        data = 8'hFF; tick(); tick();
        check("pre_rst_q", 16'(q_all[0]), 16'hFF);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_enc", 16'(g_dut[0].u_dut.encoder_out), 16'h000);
        check("async_rst_q", 16'(q_all[0]), 16'h00);
        tick();
        check("hold_rst_enc", 16'(g_dut[0].u_dut.encoder_out), 16'h000);
        check("hold_rst_q", 16'(q_all[0]), 16'h00);
        rst = 1'b0;
        tick();
        check("post_rst_enc", 16'(g_dut[0].u_dut.encoder_out), 16'hF77);
        check("post_rst_q", 16'(q_all[0]), 16'h00);
        tick();
        check("post_rst_q2", 16'(q_all[0]), 16'hFF);

        // Random sweep across every ERR_POS instance
        last = 8'hFF;
        for (int n = 0; n < 21; n++) begin
            v = 8'($urandom_range(0, 255));
            for (int r = 0; r < 2; r++) begin
                data = v;
                tick();
                for (int g = 0; g < 13; g++) begin
                    check($sformatf("sweep_e%0d_n%0d", g, n), 16'(q_all[g]), 16'(last));
                end
                last = v;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_top.md
Name: hamming_top

Overview:
- Self-contained Hamming(12,8) single-error-correcting link: an 8-bit word is encoded into a 12-bit codeword, passed through a channel stage, then decoded and corrected back to 8 bits.
- Used as a loopback/bring-up block for the transceiver's error-correction path.
- Two registered pipeline stages: encoder register, then decoder register.
- A compile-time channel error injector allows single-bit error-correction testing.

Parameters:
- ERR_POS, default 0: codeword bit position (1..12) inverted in the channel stage; 0 or any value above 12 disables injection.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all registers.
- data  input  8  payload word, sampled on every rising edge.
- q  output  8  decoded and corrected payload.

Behaviour:
- Internal signal encoder_out[11:0] is a register named exactly encoder_out at the top level, because benches probe it hierarchically.
- Codeword position numbering:
  - Positions run 1..12, with encoder_out[i-1] = position i.
  - Parity bits sit at positions 1, 2, 4 and 8.
  - Data bits map as: data[0] to pos3, data[1] to pos5, data[2] to pos6, data[3] to pos7, data[4] to pos9, data[5] to pos10, data[6] to pos11, data[7] to pos12.
- Parity is even:
  - p1 = d0^d1^d3^d4^d6
  - p2 = d0^d2^d3^d5^d6
  - p4 = d1^d2^d3^d7
  - p8 = d4^d5^d6^d7
- Stage 1 (encoder): on each rising edge, encoder_out <= encode(data).
- Channel (combinational): rx = encoder_out, with bit ERR_POS-1 inverted when 1 <= ERR_POS <= 12.
- Stage 2 (decoder), combinational part:
  - Syndrome s[3:0] = {s8, s4, s2, s1}, where each bit is the XOR of all rx positions whose index has that bit set (s1 covers positions 1,3,5,7,9,11, and so on).
  - s == 0: no error.
  - 1 <= s <= 12: invert rx position s before extraction; this includes parity-bit errors, which leave the data unchanged.
  - s in 13..15: uncorrectable; no bit is flipped and data is extracted as received.
- Stage 2, registered part: q <= extracted data bits.
- Latency: data sampled at edge k appears on encoder_out after edge k and on q after edge k+1, i.e. two clock edges from input to output.
- Throughput: one word per clock; no handshake; data is consumed every cycle.
- Reset:
  - While rst=1, encoder_out = 12'h000 and q = 8'h00, asynchronously.
  - Reset mid-stream discards in-flight words.
  - After rst falls, the first valid q follows two edges later.
  - During that latency q shows decode(12'h000) = 8'h00.
- Unknown (X) data propagates as X; no X-masking is required.
- Double-bit errors are outside the guarantee; the output may be miscorrected.

Test Plan:
- Reset: assert rst asynchronously between edges -> encoder_out = 12'h000 and q = 8'h00 immediately; both hold through reset.
- Encoding, ERR_POS=0:
  - data 8'h00 -> encoder_out 12'h000
  - data 8'h01 -> encoder_out 12'h007
  - data 8'h80 -> encoder_out 12'h888
  - data 8'hFF -> encoder_out 12'hF77
  - each codeword appears one edge after sampling.
- Latency/streaming, ERR_POS=0: apply data 8'hA5 then 8'h3C on consecutive edges -> q = 8'hA5 two edges after the first, 8'h3C on the following edge.
- Data-bit correction, ERR_POS=12: data 8'h80 -> encoder_out 12'h888 (injection is post-register); rx = 12'h088; syndrome 12; q = 8'h80.
- Parity-bit correction, ERR_POS=1: data 8'hFF -> q = 8'hFF.
- Random sweep, ERR_POS = 0 and each of 1..12: 21 random data values in 0..255, each held 2 cycles -> q equals data delayed by 2 edges in every case.
